// File: rtl/load_access_ctrl.sv
// Load access controller: accepts one load, reads the aligned word, extracts/merges the result.
// Optional LOAD_MERGE_EN: lwl/lwr merge with the latched rt value instead of zero-filling.
module load_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_load_sel,
    input  logic [31:0] req_rt_data,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [31:0] addr_q, rdata_q;
    logic [2:0]  sel_q;
    logic [7:0]  wait_cnt;
    logic        err_q, fill_q;
    logic        bad_req;
    logic [7:0]  wait_cnt_nxt;
    logic [31:0] ext;
    logic [1:0]  a;
    logic [4:0]  lsh, rsh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] lwl_v, lwr_v, lwl_mask, lwr_mask;

`ifdef LOAD_MERGE_EN
    logic [31:0] rt_q;
`else
    logic rt_unused;
    assign rt_unused = ^req_rt_data;
`endif

    assign bad_req = (req_load_sel == 3'd7)
                   || (((req_load_sel == 3'd2) || (req_load_sel == 3'd3)) && req_addr[0])
                   || ((req_load_sel == 3'd4) && (req_addr[1:0] != 2'b00));
    assign wait_cnt_nxt = wait_cnt + 8'd1;

    // Extraction works purely from latched request fields and the captured word.
    always_comb begin
        a        = addr_q[1:0];
        lsh      = {a, 3'b000};
        rsh      = {~a, 3'b000};
        lwl_mask = 32'hFFFF_FFFF << lsh;
        lwr_mask = 32'hFFFF_FFFF >> rsh;
        lwl_v    = (rdata_q << lsh) & lwl_mask;
        lwr_v    = (rdata_q >> rsh) & lwr_mask;
        half_v   = a[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (a)
            2'd0:    byte_v = rdata_q[7:0];
            2'd1:    byte_v = rdata_q[15:8];
            2'd2:    byte_v = rdata_q[23:16];
            default: byte_v = rdata_q[31:24];
        endcase
`ifdef LOAD_MERGE_EN
        lwl_v = lwl_v | (rt_q & ~lwl_mask);
        lwr_v = lwr_v | (rt_q & ~lwr_mask);
`endif
        case (sel_q)
            3'd0:    ext = {{24{byte_v[7]}}, byte_v};
            3'd1:    ext = {24'd0, byte_v};
            3'd2:    ext = {{16{half_v[15]}}, half_v};
            3'd3:    ext = {16'd0, half_v};
            3'd4:    ext = rdata_q;
            3'd5:    ext = lwl_v;
            3'd6:    ext = lwr_v;
            default: ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_rd     <= 1'b0;
            mem_addr   <= 32'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_err   <= 1'b0;
            wait_cnt   <= 8'd0;
            addr_q     <= 32'd0;
            rdata_q    <= 32'd0;
            sel_q      <= 3'd0;
            err_q      <= 1'b0;
            fill_q     <= 1'b0;
`ifdef LOAD_MERGE_EN
            rt_q       <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q    <= req_addr;
                    sel_q     <= req_load_sel;
`ifdef LOAD_MERGE_EN
                    rt_q      <= req_rt_data;
`endif
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    wait_cnt  <= 8'd0;
                    req_ready <= 1'b0;
                    err_q     <= bad_req;
                    if (bad_req) begin
                        state  <= RESP;
                        fill_q <= 1'b1;
                    end else begin
                        state  <= WAIT;
                        mem_rd <= 1'b1;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt_nxt;
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        mem_rd  <= 1'b0;
                        fill_q  <= 1'b1;
                        state   <= RESP;
                    end else if (wait_cnt_nxt == 8'(TIMEOUT_CYCLES)) begin
                        err_q   <= 1'b1;
                        mem_rd  <= 1'b0;
                        fill_q  <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    // First RESP cycle registers the result; valid rises the cycle after.
                    if (fill_q) begin
                        fill_q     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= err_q ? 32'd0 : ext;
                        resp_err   <= err_q;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_access_ctrl.sv
// Randomized self-checking bench for load_access_ctrl with a transaction-level reference model.
module tb_load_access_ctrl;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, mem_rd, mem_ack, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_rt_data, mem_addr, mem_rdata, resp_data;
    logic [2:0]  req_load_sel;

    int n_chk = 0, n_pass = 0;
    bit chk_en = 0, e_chk_addr = 0, e_chk_data = 0;
    logic e_req_ready, e_mem_rd, e_resp_valid, e_err;
    logic [31:0] e_mem_addr, e_data;

    load_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_load_sel(req_load_sel), .req_rt_data(req_rt_data),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_bad(input logic [2:0] sel, input logic [31:0] addr);
        return sel == 3'd7 || ((sel == 3'd2 || sel == 3'd3) && addr[0])
            || (sel == 3'd4 && addr[1:0] != 2'b00);
    endfunction

    // Byte-level reference: build the result byte by byte from memory and rt bytes.
    function automatic logic [31:0] model(input logic [2:0] sel, input logic [31:0] addr,
                                          input logic [31:0] rt, input logic [31:0] w);
        logic [7:0] mb[4];
        logic [7:0] rb[4];
        logic [7:0] ob[4];
        int a;
        a = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            mb[i] = w[8*i +: 8];
`ifdef LOAD_MERGE_EN
            rb[i] = rt[8*i +: 8];
`else
            rb[i] = 8'h00;
`endif
        end
        case (sel)
            3'd0: return {{24{mb[a][7]}}, mb[a]};
            3'd1: return {24'd0, mb[a]};
            3'd2: return {{16{mb[(a & 2) + 1][7]}}, mb[(a & 2) + 1], mb[a & 2]};
            3'd3: return {16'd0, mb[(a & 2) + 1], mb[a & 2]};
            3'd4: return w;
            3'd5: begin
                for (int j = 0; j < 4; j++) ob[j] = (j >= a) ? mb[j - a] : rb[j];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            3'd6: begin
                for (int j = 0; j < 4; j++) ob[j] = (j <= a) ? mb[j + 3 - a] : rb[j];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) if (chk_en) begin
        chk("req_ready", {31'd0, req_ready}, {31'd0, e_req_ready});
        chk("mem_rd", {31'd0, mem_rd}, {31'd0, e_mem_rd});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_resp_valid});
        if (e_chk_addr) chk("mem_addr", mem_addr, e_mem_addr);
        if (e_chk_data) begin
            chk("resp_data", resp_data, e_data);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
        end
    end

    task automatic junk();
        req_valid    = 1'($urandom);
        req_addr     = $urandom;
        req_load_sel = 3'($urandom);
        req_rt_data  = $urandom;
    endtask

    task automatic set_idle();
        e_req_ready = 1; e_mem_rd = 0; e_resp_valid = 0; e_chk_addr = 0; e_chk_data = 0;
    endtask

    // ack_wait: number of WAIT cycles before mem_ack (>= TMO means no ack, timeout).
    task automatic run_txn(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] rdata, input int ack_wait, input int stall);
        bit bad, got;
        logic [31:0] exp;
        bad = is_bad(sel, addr);
        exp = bad ? 32'd0 : model(sel, addr, rt, rdata);
        got = 0;
        set_idle();
        req_valid = 1; req_addr = addr; req_load_sel = sel; req_rt_data = rt;
        resp_ready = 0; mem_ack = 1'($urandom); mem_rdata = $urandom;
        @(posedge clk); #1;
        junk();
        if (!bad) begin
            for (int k = 1; k <= TMO; k++) begin
                e_req_ready = 0; e_mem_rd = 1; e_resp_valid = 0;
                e_chk_addr = 1; e_mem_addr = {addr[31:2], 2'b00};
                mem_ack = (k == ack_wait + 1);
                mem_rdata = mem_ack ? rdata : $urandom;
                got = mem_ack;
                @(posedge clk); #1;
                junk();
                if (got) break;
            end
            if (!got) exp = 32'd0;
        end
        e_req_ready = 0; e_mem_rd = 0; e_resp_valid = 0; e_chk_addr = 0;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        @(posedge clk); #1;
        for (int s = 0; s <= stall; s++) begin
            junk();
            e_resp_valid = 1; e_chk_data = 1; e_data = exp; e_err = bad || !got;
            resp_ready = (s == stall);
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        resp_ready = 0; req_valid = 0; mem_ack = 0;
        set_idle();
    endtask

    initial begin
        rst_n = 0; req_valid = 0; req_addr = 0; req_load_sel = 0; req_rt_data = 0;
        mem_ack = 0; mem_rdata = 0; resp_ready = 0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_data", resp_data, 32'd0);
        chk("rst resp_err", {31'd0, resp_err}, 32'd0);
        rst_n = 1;
        @(posedge clk); #1;
        chk_en = 1;

        // Hand-computed pins on the reference model.
        chk("model lb", model(3'd0, 32'h103, 32'h0, 32'h80AABBCC), 32'hFFFFFF80);
        chk("model lhu", model(3'd3, 32'h202, 32'h0, 32'h91234567), 32'h00009123);
`ifdef LOAD_MERGE_EN
        chk("model lwl", model(3'd5, 32'h1, 32'hAABBCCDD, 32'h11223344), 32'h223344DD);
        chk("model lwr", model(3'd6, 32'h1, 32'hAABBCCDD, 32'h11223344), 32'hAABB1122);
`else
        chk("model lwl", model(3'd5, 32'h1, 32'hAABBCCDD, 32'h11223344), 32'h22334400);
        chk("model lwr", model(3'd6, 32'h1, 32'hAABBCCDD, 32'h11223344), 32'h00001122);
`endif

        run_txn(3'd0, 32'h103, 32'h0, 32'h80AABBCC, 0, 0);
        run_txn(3'd3, 32'h202, 32'h0, 32'h91234567, 1, 0);
        run_txn(3'd2, 32'h201, 32'h0, 32'h91234567, 0, 0);
        run_txn(3'd5, 32'h1, 32'hAABBCCDD, 32'h11223344, 0, 1);
        run_txn(3'd6, 32'h2, 32'hAABBCCDD, 32'h11223344, 2, 0);
        run_txn(3'd4, 32'h40, 32'h0, 32'hDEADBEEF, 99, 0);
        run_txn(3'd4, 32'h44, 32'h0, 32'hCAFEF00D, 3, 5);
        run_txn(3'd7, 32'h48, 32'h0, 32'h12345678, 0, 2);
        run_txn(3'd4, 32'h42, 32'h0, 32'h12345678, 0, 0);

        for (int t = 0; t < 80; t++) begin
            logic [31:0] ad;
            ad = $urandom;
            if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
            run_txn(3'($urandom), ad, $urandom, $urandom, $urandom_range(0, 5),
                    $urandom_range(0, 3));
        end

        // Reset mid-WAIT abandons the read.
        set_idle();
        req_valid = 1; req_addr = 32'h80; req_load_sel = 3'd4; req_rt_data = 0;
        @(posedge clk); #1;
        req_valid = 0;
        e_req_ready = 0; e_mem_rd = 1; e_chk_addr = 1; e_mem_addr = 32'h80;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        set_idle();
        e_chk_addr = 1; e_mem_addr = 32'h0;
        rst_n = 1;
        @(posedge clk); #1;
        run_txn(3'd1, 32'h3, 32'h0, 32'h7F000000, 0, 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
